sram_ctrl: RTL

SRAM_CTRL -- requirements
Module: sram_ctrl

---
 rtl/sram_pkg.sv | 13 +
 rtl/sram_array.sv | 42 ++++
 rtl/sram_ctrl.sv | 135 +++++++++++++
 3 files changed

// File: rtl/sram_pkg.sv
// Shared types and default sizing for the SRAM controller and its storage array.
package sram_pkg;

  localparam int unsigned DEF_DATA_WIDTH    = 32;
  localparam int unsigned DEF_ADDRESS_WIDTH = 15;
  localparam int unsigned DEF_DEPTH         = 1 << DEF_ADDRESS_WIDTH;

  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_RUN   = 1'b1
  } state_e;

endpackage

// File: rtl/sram_array.sv
// DEPTH x DATA_WIDTH storage: byte-masked synchronous write, registered synchronous read, no reset.
module sram_array #(
  parameter int unsigned DATA_WIDTH    = 32,
  parameter int unsigned ADDRESS_WIDTH = 15,
  parameter int unsigned DEPTH         = 1 << ADDRESS_WIDTH
) (
  input  logic                      clock,
  input  logic                      we_i,
  input  logic                      re_i,
  input  logic [ADDRESS_WIDTH-1:0]  addr_i,
  input  logic [DATA_WIDTH-1:0]     wdata_i,
  input  logic [DATA_WIDTH/8-1:0]   be_i,
  output logic [DATA_WIDTH-1:0]     rdata_o
);

  localparam int unsigned NBYTES = DATA_WIDTH / 8;
  localparam int unsigned IDX_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [DATA_WIDTH-1:0] rdata_q;
  logic [DATA_WIDTH-1:0] bit_mask;
  logic [IDX_W-1:0]      idx;

  assign idx = addr_i[IDX_W-1:0];

  // Expand the byte enables into a per-bit write mask.
  for (genvar b = 0; b < NBYTES; b++) begin : g_mask
    assign bit_mask[b*8 +: 8] = {8{be_i[b]}};
  end

  always_ff @(posedge clock) begin
    if (we_i) begin
      mem_q[idx] <= (mem_q[idx] & ~bit_mask) | (wdata_i & bit_mask);
    end
    if (re_i) begin
      rdata_q <= mem_q[idx];
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/sram_ctrl.sv
// SRAM controller: post-reset zero-fill sweep, range-checked request handling and
// a one-cycle read response pipeline in front of sram_array.
module sram_ctrl
  import sram_pkg::*;
#(
  parameter int unsigned DATA_WIDTH     = DEF_DATA_WIDTH,
  parameter int unsigned ADDRESS_WIDTH  = DEF_ADDRESS_WIDTH,
  parameter int unsigned DEPTH          = 1 << ADDRESS_WIDTH,
  parameter bit          CLEAR_ON_RESET = 1'b1
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      reqValid,
  output logic                      reqReady,
  input  logic                      readWrite,
  input  logic [ADDRESS_WIDTH-1:0]  address,
  input  logic [DATA_WIDTH-1:0]     dataIn,
  input  logic [DATA_WIDTH/8-1:0]   byteEnable,
  output logic                      rspValid,
  output logic [DATA_WIDTH-1:0]     dataOut,
  output logic                      rspError,
  output logic                      busy
);

  localparam int unsigned NBYTES = DATA_WIDTH / 8;
  localparam state_e RESET_ST = CLEAR_ON_RESET ? ST_CLEAR : ST_RUN;
  localparam logic [ADDRESS_WIDTH:0]   DEPTH_W  = (ADDRESS_WIDTH+1)'(DEPTH);
  localparam logic [ADDRESS_WIDTH-1:0] LAST_IDX = ADDRESS_WIDTH'(DEPTH - 1);

  state_e                   state_q, state_d;
  logic [ADDRESS_WIDTH-1:0] clr_cnt_q, clr_cnt_d;
  logic                     rsp_valid_q, rsp_valid_d;
  logic                     rsp_err_q, rsp_err_d;

  logic                     clearing_c;
  logic                     clr_last_c;
  logic                     accept_c;
  logic                     in_range_c;
  logic                     arr_we_c;
  logic                     arr_re_c;
  logic [ADDRESS_WIDTH-1:0] arr_addr_c;
  logic [DATA_WIDTH-1:0]    arr_wdata_c;
  logic [NBYTES-1:0]        arr_be_c;
  logic [DATA_WIDTH-1:0]    arr_rdata;

  assign clearing_c = (state_q == ST_CLEAR);
  assign clr_last_c = (clr_cnt_q == LAST_IDX);
  assign accept_c   = reqValid & reqReady;
  assign in_range_c = ({1'b0, address} < DEPTH_W);

  // FSM state register
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= RESET_ST;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next state: sweep ends once the last word has been zeroed
  always_comb begin
    state_d = state_q;
    if (clearing_c && clr_last_c) begin
      state_d = ST_RUN;
    end
  end

  // FSM outputs: reqReady is also held low for the whole of reset
  always_comb begin
    busy     = 1'b0;
    reqReady = 1'b0;
    if (clearing_c) begin
      busy = 1'b1;
    end else begin
      reqReady = reset;
    end
  end

  // Clear counter and response pipeline
  always_comb begin
    clr_cnt_d   = clr_cnt_q;
    if (clearing_c) begin
      clr_cnt_d = clr_last_c ? '0 : clr_cnt_q + ADDRESS_WIDTH'(1);
    end
    rsp_valid_d = accept_c & readWrite;
    rsp_err_d   = accept_c & readWrite & ~in_range_c;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      clr_cnt_q   <= '0;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
    end else begin
      clr_cnt_q   <= clr_cnt_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

  // Array port mux: the sweep owns the port while clearing
  always_comb begin
    arr_we_c    = accept_c & ~readWrite & in_range_c;
    arr_re_c    = accept_c & readWrite & in_range_c;
    arr_addr_c  = address;
    arr_wdata_c = dataIn;
    arr_be_c    = byteEnable;
    if (clearing_c) begin
      arr_we_c    = 1'b1;
      arr_re_c    = 1'b0;
      arr_addr_c  = clr_cnt_q;
      arr_wdata_c = '0;
      arr_be_c    = '1;
    end
  end

  sram_array #(
    .DATA_WIDTH    (DATA_WIDTH),
    .ADDRESS_WIDTH (ADDRESS_WIDTH),
    .DEPTH         (DEPTH)
  ) u_array (
    .clock   (clock),
    .we_i    (arr_we_c),
    .re_i    (arr_re_c),
    .addr_i  (arr_addr_c),
    .wdata_i (arr_wdata_c),
    .be_i    (arr_be_c),
    .rdata_o (arr_rdata)
  );

  assign rspValid = rsp_valid_q;
  assign rspError = rsp_err_q;
  assign dataOut  = (rsp_valid_q && !rsp_err_q) ? arr_rdata : '0;

endmodule
